mole_hit_judge: RTL and testbench
=================================

// Module: mole_hit_judge
// PURPOSE
//  Consumes the 3-bit hole index from the mole state generator and the player's
//  decoded key presses. Opens a timed hit window per mole appearance, judges
//  hit/miss, and keeps score and miss counts. Ends the game after MAX_MISSES.
//  Sits between the mole state generator / keyboard decoder and the display/score logic.
// PARAMETERS
//  WINDOW_CYCLES  50_000_000  clk cycles a mole stays hittable (>=2)
//  MAX_MISSES     3           misses that end the game (1..7)
//  SCORE_W        8           score counter width
// PORTS
//  clk           in   1        system clock, rising edge
//  key_esc       in   1        reset, asynchronous, active-high
//  mole_state    in   3        hole index from mole state generator (0..7, all valid)
//  mole_tick     in   1        1-cycle pulse: generator advanced, mole_state now valid
//  key_valid     in   1        1-cycle pulse: player pressed a hole key
//  key_hole      in   3        hole index of the press, valid with key_valid
//  mole_pos      out  3        latched hole of the current mole
//  mole_visible  out  1        1 while a window is open (state ARMED)
//  hit_pulse     out  1        1-cycle pulse on a judged hit
//  miss_pulse    out  1        1-cycle pulse on a judged miss
//  score         out  SCORE_W  hit count, saturating
//  misses        out  3        miss count
//  game_over     out  1        1 in state OVER
// BEHAVIOUR
//  Reset (async, key_esc=1): state=IDLE, mole_pos=0, timer=0, score=0, misses=0.
//   All pulses, mole_visible and game_over are 0. No clock is needed to apply reset.
//  Outputs are registered. Pulses appear the cycle after the judged input is sampled.
//  States: IDLE, ARMED, HIT, MISSED, OVER.
//  IDLE/HIT/MISSED + mole_tick:
//   - latch mole_pos<=mole_state; timer<=WINDOW_CYCLES-1 -> ARMED.
//   - key_valid in these states is ignored.
//  ARMED, priority order each cycle:
//   1 key_valid & key_hole==mole_pos -> HIT.
//     score+1 (holds at all-ones), hit_pulse.
//   2 key_valid & key_hole!=mole_pos -> see CONFIGURATION.
//   3 timer==0 -> MISSED, miss_pulse, misses+1.
//   4 else timer-1.
//   A correct key on the same cycle as timer==0 is a hit.
//  mole_tick while ARMED and no hit:
//   - old window counts as a miss (miss_pulse, misses+1).
//   - then re-arm on the same edge with the new mole_state, timer reload, stay ARMED.
//   - mole_tick while ARMED with a correct key: hit scored on old mole_pos, then re-armed.
//  Miss that makes misses==MAX_MISSES:
//   - -> OVER instead of MISSED/ARMED; miss_pulse still fires.
//  OVER: all inputs ignored, counters frozen, game_over=1 until key_esc.
//  Reset mid-window: immediate return to reset values; no pulse emitted.
// CONFIGURATION
//  WRONG_KEY_PENALTY_EN defined:
//   - wrong-hole key in ARMED -> MISSED, miss_pulse, misses+1.
//  WRONG_KEY_PENALTY_EN undefined:
//   - wrong-hole key ignored; window keeps running.
// TESTING (WINDOW_CYCLES=8 for bench)
//  1 Reset, tick with mole_state=5, key_hole=5 at cycle 3 -> hit_pulse next cycle.
//    score=1, mole_visible 0.
//  2 Tick mole_state=2, no key -> 8 cycles later miss_pulse, misses=1, state MISSED.
//  3 Three expiries in a row -> game_over=1 on third miss.
//    Further ticks/keys leave score/misses unchanged.
//  4 Tick mole=4, key_hole=1:
//    - with _EN: miss_pulse, misses=1.
//    - without: no pulse, then correct key 4 -> hit.
//  5 Correct key on the timer==0 cycle -> hit_pulse, no miss_pulse.
//    mole_tick while ARMED without key -> miss_pulse and mole_pos updated same edge.
//  6 Assert key_esc mid-window (async, between edges) -> all outputs 0 immediately.
//    SCORE_W=2 with 5 hits -> score holds at 3.

Source files
------------

// File: rtl/mole_hit_judge.sv
// -----------------------------------------------------------------------------
// mole_hit_judge
// Judges whack-a-mole hits. Each mole appearance opens a timed hit window. A
// key press on the mole's hole is a hit and any other outcome is a miss. The
// block keeps the score and the miss count, and ends the game after MAX_MISSES
// misses.
//
// Optional feature: define WRONG_KEY_PENALTY_EN to make a wrong-hole key press
// during an open window count as a miss. When it is undefined, such a press is
// ignored.
//
// Ports
//   clk          in   system clock, rising edge
//   key_esc      in   asynchronous active-high reset
//   mole_state   in   hole index from the mole state generator
//   mole_tick    in   1-cycle pulse: mole_state holds a new mole
//   key_valid    in   1-cycle pulse: player pressed a hole key
//   key_hole     in   hole index of the press
//   mole_pos     out  latched hole of the current mole
//   mole_visible out  window open (ARMED)
//   hit_pulse    out  1-cycle pulse on a judged hit
//   miss_pulse   out  1-cycle pulse on a judged miss
//   score        out  saturating hit count
//   misses       out  miss count
//   game_over    out  game ended (OVER)
// -----------------------------------------------------------------------------
module mole_hit_judge #(
    parameter int unsigned WINDOW_CYCLES = 50_000_000,
    parameter int unsigned MAX_MISSES    = 3,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               key_esc,
    input  logic [2:0]         mole_state,
    input  logic               mole_tick,
    input  logic               key_valid,
    input  logic [2:0]         key_hole,
    output logic [2:0]         mole_pos,
    output logic               mole_visible,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         misses,
    output logic               game_over
);

    localparam int unsigned TIMER_W = $clog2(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [2:0] MAX_MISS_CNT = 3'(MAX_MISSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HIT,
        S_MISSED,
        S_OVER
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           mole_pos_q, mole_pos_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [2:0]           misses_q, misses_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic                 visible_q, over_q;
    logic                 key_match;
    logic                 wrong_key;
    logic                 arm;

    // State and output registers
    always_ff @(posedge clk or posedge key_esc) begin
        if (key_esc) begin
            state_q    <= S_IDLE;
            mole_pos_q <= 3'd0;
            timer_q    <= '0;
            score_q    <= '0;
            misses_q   <= 3'd0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            visible_q  <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mole_pos_q <= mole_pos_d;
            timer_q    <= timer_d;
            score_q    <= score_d;
            misses_q   <= misses_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            visible_q  <= (state_d == S_ARMED);
            over_q     <= (state_d == S_OVER);
        end
    end

    // Next-state, judging and counter updates
    always_comb begin
        state_d    = state_q;
        mole_pos_d = mole_pos_q;
        timer_d    = timer_q;
        score_d    = score_q;
        misses_d   = misses_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        arm        = 1'b0;

        key_match = key_valid && (key_hole == mole_pos_q);
`ifdef WRONG_KEY_PENALTY_EN
        wrong_key = key_valid && !key_match;
`else
        wrong_key = 1'b0;
`endif

        case (state_q)
            S_IDLE, S_HIT, S_MISSED: begin
                arm = mole_tick;
            end
            S_ARMED: begin
                if (key_match) begin
                    // A hit wins even on the expiry cycle; a tick re-arms after scoring
                    hit_d   = 1'b1;
                    state_d = S_HIT;
                    arm     = mole_tick;
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else if (wrong_key || (timer_q == '0) || mole_tick) begin
                    // A new mole arriving before a hit forfeits the old window
                    miss_d   = 1'b1;
                    misses_d = misses_q + 3'd1;
                    if (misses_d == MAX_MISS_CNT) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_MISSED;
                        arm     = mole_tick;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (arm) begin
            state_d    = S_ARMED;
            mole_pos_d = mole_state;
            timer_d    = TIMER_RELOAD;
        end
    end

    assign mole_pos     = mole_pos_q;
    assign mole_visible = visible_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = miss_q;
    assign score        = score_q;
    assign misses       = misses_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_mole_hit_judge.sv
// -----------------------------------------------------------------------------
// tb_mole_hit_judge
// Directed bench for mole_hit_judge with an 8-cycle window. A reference model
// predicts each cycle's outputs into a scoreboard queue. A second instance with
// a 2-bit score shares the stimulus to exercise score saturation.
// -----------------------------------------------------------------------------
module tb_mole_hit_judge;

    localparam int unsigned WIN  = 8;
    localparam int          MAXM = 3;
`ifdef WRONG_KEY_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_HIT    = 2;
    localparam int M_MISSED = 3;
    localparam int M_OVER   = 4;

    logic       clk = 1'b0;
    logic       key_esc;
    logic [2:0] mole_state;
    logic       mole_tick;
    logic       key_valid;
    logic [2:0] key_hole;

    logic [2:0] mole_pos,   s_mole_pos;
    logic       mole_visible, s_mole_visible;
    logic       hit_pulse,  s_hit_pulse;
    logic       miss_pulse, s_miss_pulse;
    logic [7:0] score;
    logic [1:0] s_score;
    logic [2:0] misses,     s_misses;
    logic       game_over,  s_game_over;

    always #5 clk = ~clk;

    mole_hit_judge #(.WINDOW_CYCLES(WIN), .MAX_MISSES(MAXM), .SCORE_W(8)) dut (
        .clk(clk), .key_esc(key_esc), .mole_state(mole_state), .mole_tick(mole_tick),
        .key_valid(key_valid), .key_hole(key_hole), .mole_pos(mole_pos),
        .mole_visible(mole_visible), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .score(score), .misses(misses), .game_over(game_over)
    );

    mole_hit_judge #(.WINDOW_CYCLES(WIN), .MAX_MISSES(MAXM), .SCORE_W(2)) dut_s (
        .clk(clk), .key_esc(key_esc), .mole_state(mole_state), .mole_tick(mole_tick),
        .key_valid(key_valid), .key_hole(key_hole), .mole_pos(s_mole_pos),
        .mole_visible(s_mole_visible), .hit_pulse(s_hit_pulse), .miss_pulse(s_miss_pulse),
        .score(s_score), .misses(s_misses), .game_over(s_game_over)
    );

    typedef struct packed {
        logic [2:0] pos;
        logic       vis;
        logic       hit;
        logic       miss;
        logic [7:0] score;
        logic [1:0] score_s;
        logic [2:0] misses;
        logic       over;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int         m_state;
    logic [2:0] m_pos;
    int         m_timer;
    int         m_score;
    int         m_score_s;
    int         m_misses;
    logic       m_hit;
    logic       m_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = M_IDLE;
        m_pos     = 3'd0;
        m_timer   = 0;
        m_score   = 0;
        m_score_s = 0;
        m_misses  = 0;
        m_hit     = 1'b0;
        m_miss    = 1'b0;
    endtask

    task automatic model_arm(input logic [2:0] ms);
        m_state = M_ARMED;
        m_pos   = ms;
        m_timer = WIN - 1;
    endtask

    task automatic model_step(input logic t, input logic [2:0] ms,
                              input logic kv, input logic [2:0] kh);
        m_hit  = 1'b0;
        m_miss = 1'b0;
        if (m_state == M_ARMED) begin
            if (kv && kh == m_pos) begin
                m_hit = 1'b1;
                if (m_score < 255) m_score++;
                if (m_score_s < 3) m_score_s++;
                if (t) model_arm(ms);
                else m_state = M_HIT;
            end else if ((PEN && kv) || m_timer == 0 || t) begin
                m_miss = 1'b1;
                m_misses++;
                if (m_misses == MAXM) m_state = M_OVER;
                else if (t) model_arm(ms);
                else m_state = M_MISSED;
            end else begin
                m_timer--;
            end
        end else if (m_state != M_OVER && t) begin
            model_arm(ms);
        end
    endtask

    // One clock of stimulus: predict, push, clock, pop and compare
    task automatic step(input logic t, input logic [2:0] ms,
                        input logic kv, input logic [2:0] kh);
        exp_t e;
        mole_tick  = t;
        mole_state = ms;
        key_valid  = kv;
        key_hole   = kh;
        model_step(t, ms, kv, kh);
        e.pos     = m_pos;
        e.vis     = (m_state == M_ARMED);
        e.hit     = m_hit;
        e.miss    = m_miss;
        e.score   = 8'(m_score);
        e.score_s = 2'(m_score_s);
        e.misses  = 3'(m_misses);
        e.over    = (m_state == M_OVER);
        q.push_back(e);
        @(posedge clk);
        #1;
        mole_tick = 1'b0;
        key_valid = 1'b0;
        chk("sb_depth", 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("mole_pos",     32'(mole_pos),       32'(e.pos));
            chk("mole_visible", 32'(mole_visible),   32'(e.vis));
            chk("hit_pulse",    32'(hit_pulse),      32'(e.hit));
            chk("miss_pulse",   32'(miss_pulse),     32'(e.miss));
            chk("score",        32'(score),          32'(e.score));
            chk("misses",       32'(misses),         32'(e.misses));
            chk("game_over",    32'(game_over),      32'(e.over));
            chk("s_score",      32'(s_score),        32'(e.score_s));
            chk("s_hit_pulse",  32'(s_hit_pulse),    32'(e.hit));
            chk("s_miss_pulse", 32'(s_miss_pulse),   32'(e.miss));
            chk("s_misses",     32'(s_misses),       32'(e.misses));
            chk("s_pos",        32'(s_mole_pos),     32'(e.pos));
            chk("s_visible",    32'(s_mole_visible), 32'(e.vis));
            chk("s_game_over",  32'(s_game_over),    32'(e.over));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pos"},    32'(mole_pos),     32'd0);
        chk({tag, "_vis"},    32'(mole_visible), 32'd0);
        chk({tag, "_hit"},    32'(hit_pulse),    32'd0);
        chk({tag, "_miss"},   32'(miss_pulse),   32'd0);
        chk({tag, "_score"},  32'(score),        32'd0);
        chk({tag, "_misses"}, 32'(misses),       32'd0);
        chk({tag, "_over"},   32'(game_over),    32'd0);
        chk({tag, "_sscore"}, 32'(s_score),      32'd0);
    endtask

    // Assert reset between edges, check outputs before any edge, then release
    task automatic async_reset(input string tag);
        #2;
        key_esc = 1'b1;
        #1;
        chk_all_zero(tag);
        model_reset();
        q.delete();
        @(posedge clk);
        #1;
        key_esc = 1'b0;
    endtask

    initial begin
        key_esc    = 1'b1;
        mole_state = 3'd0;
        mole_tick  = 1'b0;
        key_valid  = 1'b0;
        key_hole   = 3'd0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        key_esc = 1'b0;

        // Hit: mole 5, correct key three cycles later
        step(1'b1, 3'd5, 1'b0, 3'd0);
        idle(2);
        step(1'b0, 3'd0, 1'b1, 3'd5);
        chk("t1_hit", 32'(hit_pulse), 32'd1);
        idle(1);
        chk("t1_score", 32'(score), 32'd1);
        chk("t1_vis", 32'(mole_visible), 32'd0);

        // Expiry: mole 2 with no key, miss on the eighth cycle
        step(1'b1, 3'd2, 1'b0, 3'd0);
        idle(7);
        chk("t2_no_early_miss", 32'(miss_pulse), 32'd0);
        idle(1);
        chk("t2_miss", 32'(miss_pulse), 32'd1);
        chk("t2_misses", 32'(misses), 32'd1);

        // Wrong key on mole 4, then the correct key
        step(1'b1, 3'd4, 1'b0, 3'd0);
        step(1'b0, 3'd0, 1'b1, 3'd1);
        step(1'b0, 3'd0, 1'b1, 3'd4);
        idle(1);

        // Reset while a window is open
        step(1'b1, 3'd3, 1'b0, 3'd0);
        idle(2);
        async_reset("t6_async");

        // Correct key on the last window cycle is a hit
        step(1'b1, 3'd6, 1'b0, 3'd0);
        idle(7);
        step(1'b0, 3'd0, 1'b1, 3'd6);
        chk("t5_edge_hit", 32'(hit_pulse), 32'd1);
        chk("t5_edge_nomiss", 32'(miss_pulse), 32'd0);

        // New mole while armed: miss on the old one, re-armed on the same edge
        step(1'b1, 3'd3, 1'b0, 3'd0);
        idle(2);
        step(1'b1, 3'd7, 1'b0, 3'd0);
        chk("t5_tick_miss", 32'(miss_pulse), 32'd1);
        chk("t5_tick_pos", 32'(mole_pos), 32'd7);

        // New mole together with a correct key: hit on the old one, then re-arm
        step(1'b1, 3'd2, 1'b1, 3'd7);
        idle(3);

        // Three expiries in a row end the game; later input is ignored
        async_reset("t3_pre");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'(k), 1'b0, 3'd0);
            idle(8);
        end
        chk("t3_over", 32'(game_over), 32'd1);
        chk("t3_misses", 32'(misses), 32'd3);
        step(1'b1, 3'd6, 1'b0, 3'd0);
        step(1'b0, 3'd0, 1'b1, 3'd6);
        idle(9);
        chk("t3_frozen_misses", 32'(misses), 32'd3);
        chk("t3_frozen_score", 32'(score), 32'd0);

        // Five hits: the wide score counts them, the 2-bit score holds at 3
        async_reset("t6_sat_pre");
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 3'(k), 1'b0, 3'd0);
            step(1'b0, 3'd0, 1'b1, 3'(k));
        end
        idle(1);
        chk("t6_score5", 32'(score), 32'd5);
        chk("t6_sat", 32'(s_score), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
